// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg : shared defaults and types for the LED chaser stages
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam int N_LEDS    = 7;
  localparam int PWM_BITS  = 8;
  localparam int LEVEL_MAX = (1 << PWM_BITS) - 1;

  typedef logic [N_LEDS-1:0] led_vec_t;

  function automatic int level_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel : one brightness level with saturating decay and PWM output
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                trig,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic [PWM_BITS-1:0] level
);

  localparam logic [PWM_BITS-1:0] C_LEVEL_MAX = PWM_BITS'(level_max(PWM_BITS));
  localparam logic [PWM_BITS:0]   C_STEP      = (PWM_BITS+1)'(DECAY_STEP);

  // One extra bit catches the borrow so the level floors at zero
  logic [PWM_BITS:0] diff;
  assign diff = {1'b0, level} - C_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      led_out <= 1'b0;
    end else if (!enable) begin
      level   <= '0;
      led_out <= trig;
    end else begin
      led_out <= (pwm_cnt < level);
      if (trig) begin
        level <= C_LEVEL_MAX;
      end else if (tick) begin
        level <= diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_fader.sv
// ---------------------------------------------------------------------------
// led_fader : comet-tail fader behind the LED chaser, with registered bypass
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module led_fader #(
  parameter int N_LEDS       = led_pkg::N_LEDS,
  parameter int PWM_BITS     = led_pkg::PWM_BITS,
  parameter int DECAY_PERIOD = 65536,
  parameter int DECAY_STEP   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              active
);

  import led_pkg::*;

  localparam int                  C_PRE_W    = $clog2(DECAY_PERIOD);
  localparam logic [C_PRE_W-1:0]  C_PRE_LAST = C_PRE_W'(DECAY_PERIOD - 1);
  localparam logic [PWM_BITS-1:0] C_PWM_LAST = PWM_BITS'(level_max(PWM_BITS) - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [C_PRE_W-1:0]  pre_cnt;
  logic                tick;
  logic [N_LEDS-1:0]   lit;

  assign tick = (pre_cnt == C_PRE_LAST);

  // Bypass parks both counters at zero so fade mode restarts in phase
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      pwm_cnt <= '0;
      pre_cnt <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == C_PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
      logic [PWM_BITS-1:0] level;

      led_pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .DECAY_STEP (DECAY_STEP)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .trig    (led_in[g]),
        .tick    (tick),
        .pwm_cnt (pwm_cnt),
        .led_out (led_out[g]),
        .level   (level)
      );

      assign lit[g] = (level != '0);
    end
  endgenerate

  assign active = |lit;

endmodule

`default_nettype wire

// File: tb/tb_led_fader.sv
// ---------------------------------------------------------------------------
// tb_led_fader : directed vectors for led_fader (three parameterisations)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [6:0] led_in = 7'h7F;

  logic [6:0] out_a, out_b, out_c;
  logic       act_a, act_b, act_c;
  logic [7:0] lv_a [7];
  logic [7:0] lv_b [7];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_fader #(.N_LEDS(7), .PWM_BITS(8), .DECAY_PERIOD(4), .DECAY_STEP(64)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .led_in(led_in), .led_out(out_a), .active(act_a));
  led_fader #(.N_LEDS(7), .PWM_BITS(8), .DECAY_PERIOD(4), .DECAY_STEP(16)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .led_in(led_in), .led_out(out_b), .active(act_b));
  led_fader #(.N_LEDS(7), .PWM_BITS(8), .DECAY_PERIOD(256), .DECAY_STEP(64)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .led_in(led_in), .led_out(out_c), .active(act_c));

  generate
    for (genvar g = 0; g < 7; g++) begin : g_tap
      assign lv_a[g] = dut_a.g_ch[g].level;
      assign lv_b[g] = dut_b.g_ch[g].level;
    end
  endgenerate

  typedef struct {
    logic       r;
    logic       e;
    logic [6:0] din;
    logic [6:0] out;
    logic       act;
    int         lv0;
    int         lv2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [6:0] din,
                     input logic [6:0] out, input logic act, input int lv0, input int lv2);
    vec_t v;
    v.r = r; v.e = e; v.din = din; v.out = out; v.act = act; v.lv0 = lv0; v.lv2 = lv2;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_b [7];
    int on_cnt;
    int stray;
    int h;
    logic tk;

    // reset, pulse decay on ch0/ch2, collision on ch2, bypass, re-enable, mid-fade reset
    add(1, 1, 7'h7F, 7'h00, 0,   0,   0);
    add(1, 1, 7'h7F, 7'h00, 0,   0,   0);
    add(1, 1, 7'h7F, 7'h00, 0,   0,   0);
    add(0, 1, 7'h05, 7'h00, 1, 255, 255);
    add(0, 1, 7'h00, 7'h05, 1, 255, 255);
    add(0, 1, 7'h00, 7'h05, 1, 255, 255);
    add(0, 1, 7'h00, 7'h05, 1, 191, 191);
    add(0, 1, 7'h00, 7'h05, 1, 191, 191);
    add(0, 1, 7'h00, 7'h05, 1, 191, 191);
    add(0, 1, 7'h00, 7'h05, 1, 191, 191);
    add(0, 1, 7'h00, 7'h05, 1, 127, 127);
    add(0, 1, 7'h00, 7'h05, 1, 127, 127);
    add(0, 1, 7'h00, 7'h05, 1, 127, 127);
    add(0, 1, 7'h00, 7'h05, 1, 127, 127);
    add(0, 1, 7'h04, 7'h05, 1,  63, 255);
    add(0, 1, 7'h00, 7'h05, 1,  63, 255);
    add(0, 1, 7'h00, 7'h05, 1,  63, 255);
    add(0, 1, 7'h00, 7'h05, 1,  63, 255);
    add(0, 1, 7'h00, 7'h05, 1,   0, 191);
    add(0, 1, 7'h00, 7'h04, 1,   0, 191);
    add(0, 0, 7'h2A, 7'h2A, 0,   0,   0);
    add(0, 0, 7'h15, 7'h15, 0,   0,   0);
    add(0, 1, 7'h01, 7'h00, 1, 255,   0);
    add(0, 1, 7'h00, 7'h01, 1, 255,   0);
    add(0, 1, 7'h00, 7'h01, 1, 255,   0);
    add(0, 1, 7'h00, 7'h01, 1, 191,   0);
    add(1, 1, 7'h7F, 7'h00, 0,   0,   0);
    add(0, 1, 7'h00, 7'h00, 0,   0,   0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; enable = tbl[i].e; led_in = tbl[i].din;
      step();
      chk($sformatf("vec%0d led_out", i), int'(out_a), int'(tbl[i].out));
      chk($sformatf("vec%0d active", i), int'(act_a), int'(tbl[i].act));
      chk($sformatf("vec%0d level0", i), int'(lv_a[0]), tbl[i].lv0);
      chk($sformatf("vec%0d level2", i), int'(lv_a[2]), tbl[i].lv2);
    end

    // Held input: ch3 stays at full level across ticks and its output stays on
    rst = 1'b1; enable = 1'b1; led_in = 7'h00;
    step();
    rst = 1'b0; led_in = 7'h08;
    for (int c = 0; c < 40; c++) begin
      step();
      chk($sformatf("held c%0d level3", c), int'(lv_a[3]), 255);
      if (c >= 1) chk($sformatf("held c%0d out3", c), int'(out_a[3]), 1);
    end
    led_in = 7'h00;

    // PWM on-count per 255-cycle window at each plateau (decay period 256)
    rst = 1'b1;
    step();
    rst = 1'b0; led_in = 7'h01;
    step();
    led_in = 7'h00;
    stray = 0;
    for (int j = 0; j < 5; j++) begin
      on_cnt = 0;
      repeat (255) begin
        step();
        on_cnt += int'(out_c[0]);
        stray  += int'(out_c[6:1] != 6'h00);
      end
      chk($sformatf("pwm window%0d on-count", j), on_cnt, (j == 4) ? 0 : 255 - 64 * j);
      step();
    end
    chk("pwm other channels lit", stray, 0);
    chk("pwm active after full decay", int'(act_c), 0);

    // Chaser sweep with step 16: track every level against a reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) exp_b[i] = 0;
    for (int c = 0; c < 80; c++) begin
      led_in = 7'(1 << ((c / 8) % 7));
      step();
      tk = ((c % 4) == 3);
      for (int i = 0; i < 7; i++) begin
        if (led_in[i])  exp_b[i] = 255;
        else if (tk)    exp_b[i] = (exp_b[i] > 16) ? exp_b[i] - 16 : 0;
        chk($sformatf("sweep c%0d level%0d", c, i), int'(lv_b[i]), exp_b[i]);
      end
    end
    h = (79 / 8) % 7;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("sweep tail order k%0d", k),
          int'(lv_b[(h - k + 7) % 7] > lv_b[(h - k + 6) % 7]), 1);
    end
    chk("sweep active", int'(act_b), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_fader.md
# led_fader

Downstream stage of the LED chaser. Consumes the 7-bit one-hot chaser vector and drives the physical LEDs with a fading "comet tail". Any LED the chaser lights is set to full brightness, then decays in fixed steps at a programmable rate. Brightness is rendered with per-LED PWM. With `enable` low the block passes the chaser vector straight through, registered.

## Interface
- `N_LEDS`, 7, number of LED channels
- `PWM_BITS`, 8, brightness resolution; `LEVEL_MAX` = 2^PWM_BITS-1
- `DECAY_PERIOD`, 65536, clk cycles per decay tick (≥2)
- `DECAY_STEP`, 16, brightness decrement per decay tick (1..LEVEL_MAX)

- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  reset; synchronous, active-high
- `enable`  in  1  1 = fade mode; 0 = bypass mode
- `led_in`  in  N_LEDS  chaser vector, same clock domain; any number of bits may be set
- `led_out`  out  N_LEDS  registered LED drive
- `active`  out  1  1 when any channel level ≠ 0

## Operation
- **State**
  - `level[i]`: PWM_BITS per channel.
  - `pwm_cnt`: free-running 0..LEVEL_MAX-1, wraps to 0. Period is LEVEL_MAX cycles.
  - `pre_cnt`: 0..DECAY_PERIOD-1, wraps to 0.
  - `tick` = (`pre_cnt` == DECAY_PERIOD-1).
- **Fade mode** (`enable`=1), every cycle, per channel, first match wins:
  - `led_in[i]`=1 → `level[i]` ← LEVEL_MAX.
  - `tick` → `level[i]` ← saturating `level[i]` − DECAY_STEP, floored at 0. No wrap below 0.
  - Otherwise hold.
- **PWM output**
  - `led_out[i]` ← (`pwm_cnt` < `level[i]`), registered.
  - LEVEL_MAX → always on. 0 → always off.
  - Level L → exactly L on-cycles per PWM period.
- **Bypass mode** (`enable`=0)
  - `led_out` ← `led_in`, registered.
  - All `level` ← 0; `pwm_cnt` ← 0; `pre_cnt` ← 0.
- **Leaving bypass**: fade mode resumes with counters at 0. Only channels with `led_in` high light up.
- `active`: combinational OR-reduce of (`level[i]` ≠ 0). Driven from registers only.
- **Width rules**
  - Subtraction is done at PWM_BITS+1 bits and clamped.
  - `pre_cnt` width = clog2(DECAY_PERIOD).

## Timing
- **Reset** (`rst`=1 at an edge): `level`=0, `pwm_cnt`=0, `pre_cnt`=0, `led_out`=0, `active`=0. Reset overrides `enable` and `led_in`, including mid-fade.
- **Fade latency**
  - `led_in[i]` sampled high at edge k → `level[i]`=LEVEL_MAX after edge k.
  - `led_out[i]`=1 after edge k+1 (2-cycle latency).
  - `active`=1 after edge k.
- **Bypass latency**: 1 cycle, `led_in` to `led_out`.
- **Decay ticks**
  - First tick after reset is at cycle DECAY_PERIOD-1; then every DECAY_PERIOD cycles.
  - A level change takes effect on `led_out` at the next edge. Mid-PWM-period changes are allowed (no double buffering).
- **Simultaneous events**: `led_in` high on a tick cycle → LEVEL_MAX; the decrement is lost.
- **Full decay**: channel reaches 0 after ceil(LEVEL_MAX/DECAY_STEP) ticks without re-trigger.

## Structure
- **Shared package `led_pkg`**: default N_LEDS, PWM_BITS, LEVEL_MAX derivation, `led_vec_t` (N_LEDS-bit vector). The chaser and any later LED stages use the same package.
- **Sub-module `led_pwm_channel`**: one `level` register, saturating decay, comparator, output flop. Instantiated N_LEDS times.
- **Top level**: owns `pwm_cnt`, `pre_cnt`/`tick`, the bypass mux, and `active`.

## Test plan
Benches use DECAY_PERIOD=4, DECAY_STEP=64 unless noted.
1. **Reset**: hold `rst` 3 cycles with `led_in`=7'h7F, `enable`=1 → `led_out`=0, `active`=0 throughout.
2. **Single pulse decay**: `led_in`=7'b0000001 for one cycle.
   - Per tick, `level[0]` goes 255 → 191 → 127 → 63 → 0.
   - PWM on-count per 255-cycle period matches the level.
   - `active` falls after the 4th tick; other channels stay 0.
3. **Held input**: `led_in`[3]=1 for 40 cycles → `led_out`[3]=1 continuously from cycle 2; `level[3]` stays 255 across ticks.
4. **Collision**: `led_in`[2] pulsed exactly on a tick cycle with `level[2]`=127 → `level[2]`=255, not 63.
5. **Bypass**: drop `enable` mid-decay, then drive `led_in`=7'b0101010.
   - Next edge: all `level`=0, `active`=0.
   - `led_out`=7'b0101010 one cycle after `led_in`.
   - Re-enable: `pre_cnt` and `pwm_cnt` restart at 0.
6. **Chaser sweep**: drive a rotating one-hot `led_in` (step every 8 cycles) with DECAY_STEP=16 → trailing channels hold strictly decreasing levels; no level underflows.
